// File: rtl/dbg_mem_loader.sv
// Debug-port program loader: packs a byte stream into little-endian words and writes
// or verifies them through the CPU debug memory port while the CPU is held in reset.
module dbg_mem_loader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int LEN_W    = 16,
  parameter bit AUTO_RUN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_adr,
  input  logic [LEN_W-1:0]    start_len,
  input  logic                start_mode,
  input  logic                run,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                dbg_mem_op,
  output logic [DATA_W/8-1:0] dbg_wren,
  output logic [ADDR_W-1:0]   dbg_adr,
  output logic [DATA_W-1:0]   dbg_do,
  input  logic [DATA_W-1:0]   dbg_di,
  input  logic                dbg_ready,
  output logic                cpu_n_reset,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   err_adr,
  output logic [2:0]          fsm_state
);
  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = (NB > 1) ? $clog2(NB) : 1;

  // Handshakes: a stream byte transfers on a rising edge with s_valid && s_ready.
  // A debug access holds dbg_mem_op/dbg_adr/dbg_wren/dbg_do stable until the edge
  // where dbg_ready is high; that edge completes it and, for reads, captures dbg_di.
  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    IDLE    = 3'd1,
    COLLECT = 3'd2,
    ACCESS  = 3'd3,
    CHECK   = 3'd4,
    FINISH  = 3'd5
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] adr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              mode_q;
  logic [LANE_W-1:0] lane_q;
  logic [NB-1:0]     mask_q, mask_d;
  logic [DATA_W-1:0] word_q, word_d, rdata_q;
  logic              accept, last_byte, mismatch, advance;

  assign fsm_state = state_q;
  assign accept    = s_valid && s_ready;
  assign last_byte = (lane_q == LANE_W'(NB - 1)) || (rem_q == LEN_W'(1));
  assign advance   = (state_q == ACCESS && dbg_ready && !mode_q) ||
                     (state_q == CHECK && !mismatch);

  always_comb begin
    word_d = word_q;
    mask_d = mask_q;
    word_d[{lane_q, 3'b000} +: 8] = s_data;
    mask_d[lane_q] = 1'b1;
  end

  // Only lanes that carried stream bytes take part in the verify comparison.
  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (mask_q[i] && (rdata_q[i*8 +: 8] != word_q[i*8 +: 8])) mismatch = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HOLD;
      adr_q       <= '0;
      rem_q       <= '0;
      mode_q      <= 1'b0;
      lane_q      <= '0;
      mask_q      <= '0;
      word_q      <= '0;
      rdata_q     <= '0;
      s_ready     <= 1'b0;
      dbg_mem_op  <= 1'b0;
      dbg_wren    <= '0;
      dbg_adr     <= '0;
      dbg_do      <= '0;
      cpu_n_reset <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_adr     <= '0;
    end else begin
      case (state_q)
        HOLD, IDLE: begin
          if (start) begin
            adr_q       <= start_adr & ~ADDR_W'(NB - 1);
            rem_q       <= start_len;
            mode_q      <= start_mode;
            lane_q      <= '0;
            mask_q      <= '0;
            word_q      <= '0;
            err         <= 1'b0;
            cpu_n_reset <= 1'b0;
            if (start_len != '0) begin
              state_q <= COLLECT;
              s_ready <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state_q <= FINISH;
              done    <= 1'b1;
            end
          end else if (run && state_q == HOLD) begin
            state_q     <= IDLE;
            cpu_n_reset <= 1'b1;
          end
        end
        COLLECT: begin
          if (accept) begin
            word_q <= word_d;
            mask_q <= mask_d;
            rem_q  <= rem_q - LEN_W'(1);
            lane_q <= lane_q + LANE_W'(1);
            if (last_byte) begin
              state_q    <= ACCESS;
              s_ready    <= 1'b0;
              dbg_mem_op <= 1'b1;
              dbg_adr    <= adr_q;
              dbg_wren   <= mode_q ? '0 : mask_d;
              dbg_do     <= mode_q ? '0 : word_d;
            end
          end
        end
        ACCESS: begin
          if (dbg_ready) begin
            dbg_mem_op <= 1'b0;
            dbg_wren   <= '0;
            if (mode_q) begin
              rdata_q <= dbg_di;
              state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          if (mismatch) begin
            err     <= 1'b1;
            err_adr <= adr_q;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= FINISH;
          end
        end
        FINISH: begin
          done <= 1'b0;
          if (AUTO_RUN && !mode_q && !err) begin
            state_q     <= IDLE;
            cpu_n_reset <= 1'b1;
          end else begin
            state_q <= HOLD;
          end
        end
        default: state_q <= HOLD;
      endcase

      // Word completed (written, or verified clean): step to the next word.
      if (advance) begin
        adr_q  <= adr_q + ADDR_W'(NB);
        lane_q <= '0;
        mask_q <= '0;
        word_q <= '0;
        if (rem_q != '0) begin
          state_q <= COLLECT;
          s_ready <= 1'b1;
        end else begin
          state_q <= FINISH;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dbg_mem_loader.sv
// Bench for dbg_mem_loader: random stream/latency stimulus against a byte-level
// memory model and a word-level expected access list derived from the load rules.
module tb_dbg_mem_loader;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;
  localparam int NB     = DATA_W / 8;
  localparam int EW     = ADDR_W + NB + DATA_W;
  localparam bit AUTO_RUN = 1'b1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_adr = '0;
  logic [LEN_W-1:0]  start_len = '0;
  logic              start_mode = 1'b0;
  logic              run = 1'b0;
  logic [7:0]        s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              dbg_mem_op;
  logic [NB-1:0]     dbg_wren;
  logic [ADDR_W-1:0] dbg_adr;
  logic [DATA_W-1:0] dbg_do;
  logic [DATA_W-1:0] dbg_di = '0;
  logic              dbg_ready = 1'b0;
  logic              cpu_n_reset;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] err_adr;
  logic [2:0]        fsm_state;

  // Clock / reset block
  always #5 clk = ~clk;

  dbg_mem_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .AUTO_RUN(AUTO_RUN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_adr(start_adr),
    .start_len(start_len), .start_mode(start_mode), .run(run),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dbg_mem_op(dbg_mem_op), .dbg_wren(dbg_wren), .dbg_adr(dbg_adr),
    .dbg_do(dbg_do), .dbg_di(dbg_di), .dbg_ready(dbg_ready),
    .cpu_n_reset(cpu_n_reset), .busy(busy), .done(done), .err(err),
    .err_adr(err_adr), .fsm_state(fsm_state)
  );

  int checks = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  logic [7:0]    mem [logic [31:0]];
  logic [7:0]    stream_b [0:63];
  int            resp_delay_min = 0;
  int            resp_delay_max = 0;
  int            op_seen = 0;
  bit            exp_err;
  logic [31:0]   exp_err_adr;
  int            exp_consumed;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Reference model: words are consecutive groups of NB stream bytes from the aligned base.
  task automatic model_load(input logic [31:0] sadr, input int len, input bit mode);
    logic [31:0] base, a;
    logic [NB-1:0] m;
    logic [DATA_W-1:0] d;
    bit bad;
    base = sadr & ~32'(NB - 1);
    exp_err = 1'b0;
    exp_err_adr = '0;
    exp_consumed = len;
    for (int w = 0; w * NB < len; w++) begin
      a = base + 32'(w * NB);
      m = '0;
      d = '0;
      bad = 1'b0;
      for (int l = 0; l < NB; l++) begin
        if (w * NB + l < len) begin
          m[l] = 1'b1;
          d[l*8 +: 8] = stream_b[w * NB + l];
          if (mode && mem_rd(a + 32'(l)) != stream_b[w * NB + l]) bad = 1'b1;
        end
      end
      exp_q.push_back({a, mode ? '0 : m, mode ? '0 : d});
      if (bad) begin
        exp_err = 1'b1;
        exp_err_adr = a;
        exp_consumed = (w * NB + NB < len) ? w * NB + NB : len;
        break;
      end
    end
  endtask

  // Debug-port responder: random acknowledge latency, memory model, scoreboard.
  bit            r_in_req = 1'b0;
  int            r_stall = 0;
  logic [EW-1:0] r_held;
  logic [EW-1:0] r_exp;

  initial begin : responder
    forever begin
      @(negedge clk);
      if (dbg_mem_op) check_eq("op_while_cpu_run", cpu_n_reset, 1'b0);
      if (dbg_ready || reset || !dbg_mem_op) begin
        dbg_ready = 1'b0;
        r_in_req = 1'b0;
      end else begin
        if (!r_in_req) begin
          r_in_req = 1'b1;
          op_seen++;
          r_stall = $urandom_range(resp_delay_max, resp_delay_min);
          r_held = {dbg_adr, dbg_wren, dbg_do};
        end else begin
          check_eq("stall_stable", {dbg_adr, dbg_wren, dbg_do}, r_held);
        end
        if (r_stall == 0) begin
          dbg_ready = 1'b1;
          if (dbg_wren != '0) begin
            for (int l = 0; l < NB; l++)
              if (dbg_wren[l]) mem[dbg_adr + 32'(l)] = dbg_do[l*8 +: 8];
          end else begin
            for (int l = 0; l < NB; l++) dbg_di[l*8 +: 8] = mem_rd(dbg_adr + 32'(l));
          end
          check_eq("access_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            r_exp = exp_q.pop_front();
            if (r_exp[DATA_W +: NB] == '0)
              check_eq("read_access", {dbg_adr, dbg_wren}, r_exp[EW-1:DATA_W]);
            else
              check_eq("write_access", {dbg_adr, dbg_wren, dbg_do}, r_exp);
          end
        end else begin
          r_stall--;
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check_eq(tag, {s_ready, dbg_mem_op, dbg_wren, dbg_adr, dbg_do, cpu_n_reset,
                   busy, done, err, err_adr, fsm_state}, 128'd0);
  endtask

  // Driver: issue a start, feed the stream with random gaps, wait for done, check outcome.
  task automatic run_load(input string tag, input logic [31:0] sadr, input int len,
                          input bit mode, input bit poke_start);
    int acc = 0;
    int cyc = 0;
    bit got_done = 1'b0;
    bit exp_idle;
    int ops0;
    model_load(sadr, len, mode);
    exp_idle = AUTO_RUN && !mode && !exp_err;
    ops0 = op_seen;
    @(negedge clk);
    start = 1'b1;
    start_adr = sadr;
    start_len = 16'(len);
    start_mode = mode;
    run = 1'($urandom_range(1, 0));
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      run = 1'b0;
      start_adr = $urandom;
      start_len = 16'($urandom);
      start_mode = 1'($urandom);
      if (cyc == 1) begin
        check_eq({tag, "_cpu_held"}, cpu_n_reset, 1'b0);
        check_eq({tag, "_busy_start"}, busy, len != 0);
        check_eq({tag, "_err_cleared"}, err, 1'b0);
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (poke_start && len != 0 && cyc == 3) start = 1'b1;
      if (acc < len && $urandom_range(3, 0) != 0) begin
        s_valid = 1'b1;
        s_data = stream_b[acc];
        if (s_ready) acc++;
      end else begin
        s_valid = 1'b0;
        s_data = 8'($urandom);
      end
    end
    s_valid = 1'b0;
    check_eq({tag, "_done"}, got_done, 1'b1);
    if (len == 0) begin
      check_eq({tag, "_len0_latency"}, cyc, 1);
      check_eq({tag, "_len0_no_access"}, op_seen - ops0, 0);
    end
    check_eq({tag, "_busy_at_done"}, busy, 1'b0);
    check_eq({tag, "_err"}, err, exp_err);
    if (exp_err) check_eq({tag, "_err_adr"}, err_adr, exp_err_adr);
    check_eq({tag, "_bytes_taken"}, acc, exp_consumed);
    check_eq({tag, "_accesses_left"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check_eq({tag, "_end_state"}, fsm_state, exp_idle ? 3'd1 : 3'd0);
    check_eq({tag, "_cpu_n_reset"}, cpu_n_reset, exp_idle);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] sadr, base;
    logic [7:0]  prog [0:7];
    int len, ops0, acc, cyc, idx;
    bit mode;

    prog[0] = 8'h37; prog[1] = 8'h01; prog[2] = 8'h00; prog[3] = 8'h00;
    prog[4] = 8'h93; prog[5] = 8'h07; prog[6] = 8'h20; prog[7] = 8'h03;

    repeat (3) @(negedge clk);
    check_reset_state("reset_values");
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("after_reset_release");

    // Directed write of a two-word program, then a partial trailing word.
    for (int i = 0; i < 8; i++) stream_b[i] = prog[i];
    run_load("wr8", 32'h0002_0000, 8, 1'b0, 1'b0);
    check_eq("wr8_word0", {mem_rd(32'h20003), mem_rd(32'h20002), mem_rd(32'h20001), mem_rd(32'h20000)}, 32'h0000_0137);
    check_eq("wr8_word1", {mem_rd(32'h20007), mem_rd(32'h20006), mem_rd(32'h20005), mem_rd(32'h20004)}, 32'h0320_0793);

    stream_b[0] = 8'h13; stream_b[1] = 8'h05; stream_b[2] = 8'h10; stream_b[3] = 8'h00;
    stream_b[4] = 8'h6f; stream_b[5] = 8'hA0;
    run_load("wr6", 32'h0002_000C, 6, 1'b0, 1'b0);
    check_eq("wr6_tail_lanes", {mem.exists(32'h20013), mem.exists(32'h20012)}, 2'b00);

    // Clean verify leaves the CPU in HOLD until run.
    for (int i = 0; i < 8; i++) stream_b[i] = prog[i];
    run_load("vfy_ok", 32'h0002_0000, 8, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("hold_until_run", {fsm_state, cpu_n_reset}, {3'd0, 1'b0});
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check_eq("run_release", {fsm_state, cpu_n_reset}, {3'd1, 1'b1});

    // Verify with byte 5 corrupted; bytes beyond the failing word stay unconsumed.
    for (int i = 0; i < 12; i++) stream_b[i] = mem_rd(32'h20000 + 32'(i));
    stream_b[5] = stream_b[5] ^ 8'h40;
    run_load("vfy_bad", 32'h0002_0000, 12, 1'b1, 1'b0);
    check_eq("vfy_bad_err_adr_fixed", err_adr, 32'h0002_0004);
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("s_ready_after_err", s_ready, 1'b0);
    end
    s_valid = 1'b0;
    check_eq("err_sticky", {err, cpu_n_reset}, {1'b1, 1'b0});

    // Slow acknowledge, then an empty load.
    resp_delay_min = 5;
    resp_delay_max = 5;
    for (int i = 0; i < 8; i++) stream_b[i] = 8'($urandom);
    run_load("stall", 32'h0002_0101, 8, 1'b0, 1'b1);
    resp_delay_min = 0;
    resp_delay_max = 0;
    run_load("len0", 32'h0002_0200, 0, 1'b0, 1'b0);

    // Reset after three collected bytes.
    ops0 = op_seen;
    @(negedge clk);
    start = 1'b1;
    start_adr = 32'h0003_0000;
    start_len = 16'd10;
    start_mode = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      s_valid = 1'b1;
      s_data = 8'($urandom);
      if (s_ready) acc++;
    end
    check_eq("mid_reset_bytes_fed", acc, 3);
    @(negedge clk);
    s_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("mid_op_reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("after_mid_op_reset");
    check_eq("mid_reset_no_access", op_seen - ops0, 0);

    // Randomized loads, including address wrap and corrupted verifies.
    for (int it = 0; it < 40; it++) begin
      sadr = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15, 0))
                                         : 32'h0004_0000 + 32'($urandom_range(255, 0));
      base = sadr & ~32'(NB - 1);
      len = $urandom_range(20, 0);
      mode = 1'($urandom_range(1, 0));
      for (int b = 0; b < len; b++)
        stream_b[b] = mode ? mem_rd(base + 32'(b)) : 8'($urandom);
      if (mode && len > 0 && $urandom_range(1, 0) == 1) begin
        idx = $urandom_range(len - 1, 0);
        stream_b[idx] = stream_b[idx] ^ (8'h01 << $urandom_range(7, 0));
      end
      resp_delay_max = $urandom_range(3, 0);
      run_load("rand", sadr, len, mode, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dbg_mem_loader.md
Name: dbg_mem_loader

Overview:
- Hardware program loader for the CPU debug memory port.
- Takes a byte stream plus a start command and assembles little-endian words. Drives dbg_mem_op/dbg_adr/dbg_do/dbg_wren with per-lane byte-enable masks, holding the CPU in reset throughout.
- Generalises the forced-poke load sequence: parametrised data width, partial trailing-word masks, handshaked memory access, and a read-back verify mode.
- Sits between the UART/debug receiver and the SoC debug memory port.

Parameters:
- DATA_W, 32, debug port data width; multiple of 8; NB = DATA_W/8 byte lanes.
- ADDR_W, 32, debug port address width.
- LEN_W, 16, width of byte-count command field.
- AUTO_RUN, 1, if 1 release CPU reset after a successful write-mode load.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command pulse; sampled only in IDLE/HOLD.
- start_adr  in  ADDR_W  load base address; low log2(NB) bits ignored (forced 0).
- start_len  in  LEN_W  number of bytes to load.
- start_mode  in  1  0 = write, 1 = verify.
- run  in  1  pulse: release CPU reset from HOLD.
- s_data  in  8  stream byte.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- dbg_mem_op  out  1  debug access request.
- dbg_wren  out  NB  byte write mask; 0 = read.
- dbg_adr  out  ADDR_W  debug access address.
- dbg_do  out  DATA_W  write data.
- dbg_di  in  DATA_W  read data, valid with dbg_ready on reads.
- dbg_ready  in  1  single-cycle access acknowledge.
- cpu_n_reset  out  1  CPU reset, active low.
- busy  out  1  load/verify in progress.
- done  out  1  one-cycle pulse at completion.
- err  out  1  verify mismatch flag; sticky until next start.
- err_adr  out  ADDR_W  word address of first mismatch.

Behaviour:
- Reset values:
  - State HOLD.
  - cpu_n_reset=0, s_ready=0, dbg_mem_op=0, dbg_wren=0, dbg_adr=0, dbg_do=0.
  - busy=0, done=0, err=0, err_adr=0.
- States: HOLD, IDLE, COLLECT, ACCESS, CHECK, FINISH.
- HOLD:
  - cpu_n_reset=0.
  - run -> IDLE.
  - start -> latch adr/len/mode, clear err, then go to COLLECT (len!=0) or FINISH (len==0).
  - start has priority over run in the same cycle.
- IDLE:
  - cpu_n_reset=1.
  - start behaves as in HOLD, and also drives cpu_n_reset=0 on the next cycle.
- COLLECT:
  - s_ready=1, busy=1.
  - Each accepted byte k goes to lane k mod NB of the word register and sets its mask bit.
  - Go to ACCESS when the lane NB-1 byte is accepted or the remaining count reaches 0.
  - s_ready drops the cycle after the transition; no byte is lost or duplicated.
- ACCESS:
  - dbg_mem_op=1 and dbg_adr=word address.
  - Write mode: dbg_wren = collected mask (full 'hF or partial, e.g. 4'h3 for 2 trailing bytes); dbg_do = word, unfilled lanes 0.
  - Verify mode: dbg_wren=0.
  - Request stays asserted with stable outputs until dbg_ready.
  - On dbg_ready: write -> next word; verify -> CHECK with dbg_di captured.
- CHECK (1 cycle):
  - Compare only the masked lanes.
  - Mismatch: err=1, err_adr=word address, go to FINISH; remaining stream bytes are not consumed.
  - Match: next word.
- Next word:
  - Address += NB, clear mask/word.
  - Go to COLLECT if bytes remain, else FINISH.
- Address wraps modulo 2^ADDR_W.
- FINISH (1 cycle):
  - done=1, busy=0.
  - Go to IDLE if AUTO_RUN && mode==write && !err; otherwise go to HOLD.
- start while busy is ignored.
- reset mid-operation: immediate return to HOLD with all outputs at reset values; the partial word is discarded, not written.
- dbg_mem_op is never asserted while cpu_n_reset=1.

Test Plan:
- Write 8 bytes 37 01 00 00 93 07 20 03 at 0x20000 -> two accesses:
  - 0x20000/0x00000137, wren F;
  - 0x20004/0x03200793, wren F;
  - then done, and cpu_n_reset=1 (AUTO_RUN=1).
- Write 6 bytes at 0x2000C -> 0x2000C wren F, then 0x20010 wren 4'h3 with upper lanes 0.
- Verify 8 bytes against a memory model holding the same data -> err=0, done, CPU stays in HOLD until a run pulse.
- Verify with byte 5 corrupted -> err=1, err_adr=0x20004, s_ready low afterwards, cpu_n_reset=0.
- dbg_ready delayed 5 cycles, and start_len=0 -> outputs stable during the stall; len 0 gives done the cycle after start with no access.
- Assert reset after 3 bytes collected -> no dbg_mem_op issued, all outputs at reset values, state HOLD.
